// File: rtl/memory_bank_if.sv
// -----------------------------------------------------------------------------
// memory_bank_if
// Bundles the board-side signals of memory_bank.
//   data   : word to store                (master -> slave)
//   addr   : write / display address      (master -> slave)
//   store  : level, rising edge = write   (master -> slave)
//   clear  : level, rising edge = clear   (master -> slave)
//   memory : registered read data         (slave -> master)
//   valid  : registered valid bit         (slave -> master)
//   count  : number of valid words        (slave -> master)
//   busy   : clear sequencer running      (slave -> master)
// -----------------------------------------------------------------------------
interface memory_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  store;
  logic                  clear;
  logic [DATA_WIDTH-1:0] memory;
  logic                  valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;

  modport master (
    output data, addr, store, clear,
    input  memory, valid, count, busy
  );

  modport slave (
    input  data, addr, store, clear,
    output memory, valid, count, busy
  );
endinterface

// File: rtl/memory_bank.sv
// -----------------------------------------------------------------------------
// memory_bank
// DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits behind one shared address.
// Rising edges on store/clear request a write of data to word[addr] or a
// multi-cycle clear-all sweep. The addressed word is shown on a registered,
// write-first read port, masked to zero when the word is not valid.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   bus.data   : word to store
//   bus.addr   : write and display address
//   bus.store  : level; rising edge writes
//   bus.clear  : level; rising edge starts clear-all
//   bus.memory : word[addr] (0 if invalid), one cycle latency
//   bus.valid  : valid bit of word[addr], one cycle latency
//   bus.count  : number of valid words, 0..DEPTH
//   bus.busy   : high for exactly DEPTH cycles while clearing
// -----------------------------------------------------------------------------
module memory_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  memory_bank_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  store_q, clear_q;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] memory_q, memory_d;
  logic                  rvalid_q;
  logic                  busy_q;

  // Array contents are never reset; the valid bits mask stale data.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  st_edge, cl_edge;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] word_next;

  assign st_edge = bus.store & ~store_q;
  assign cl_edge = bus.clear & ~clear_q;

  // ---- next-state: edge requests, FSM, valid bits and occupancy ----
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    count_d = count_q;
    we      = 1'b0;
    waddr   = bus.addr;
    wdata   = bus.data;
    unique case (state_q)
      IDLE: begin
        // Clear takes priority; a coincident store edge is dropped.
        if (cl_edge) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (st_edge) begin
          we                = 1'b1;
          valid_d[bus.addr] = 1'b1;
          if (!valid_q[bus.addr]) count_d = count_q + CW'(1);
        end
      end
      CLEAR: begin
        // One word per cycle; edges arriving now are discarded.
        we             = 1'b1;
        waddr          = ptr_q;
        wdata          = '0;
        valid_d[ptr_q] = 1'b0;
        if (valid_q[ptr_q]) count_d = count_q - CW'(1);
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Write-first bypass so a write to the displayed word shows without a bubble.
    word_next = (we && (waddr == bus.addr)) ? wdata : mem_q[bus.addr];
    memory_d  = valid_d[bus.addr] ? word_next : '0;
  end

  // ---- register stage: control state and registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      store_q  <= 1'b1;   // a level held through reset must not fire afterwards
      clear_q  <= 1'b1;
      valid_q  <= '0;
      count_q  <= '0;
      memory_q <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      store_q  <= bus.store;
      clear_q  <= bus.clear;
      valid_q  <= valid_d;
      count_q  <= count_d;
      memory_q <= memory_d;
      rvalid_q <= valid_d[bus.addr];
      busy_q   <= (state_d == CLEAR);
    end
  end

  // ---- storage array: data only, no reset ----
  always_ff @(posedge clk) begin
    if (!rst && we) mem_q[waddr] <= wdata;
  end

  assign bus.memory = memory_q;
  assign bus.valid  = rvalid_q;
  assign bus.count  = count_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_memory_bank.sv
module tb_memory_bank;
  localparam int DWA = 8;
  localparam int AWA = 2;
  localparam int DWB = 16;
  localparam int AWB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  memory_bank_if #(.DATA_WIDTH(DWA), .ADDR_WIDTH(AWA)) bus_a();
  memory_bank_if #(.DATA_WIDTH(DWB), .ADDR_WIDTH(AWB)) bus_b();

  memory_bank #(.DATA_WIDTH(DWA), .ADDR_WIDTH(AWA)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a.slave));
  memory_bank #(.DATA_WIDTH(DWB), .ADDR_WIDTH(AWB)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave));

  typedef struct packed {
    logic [15:0] mem;
    logic        vld;
    logic [3:0]  cnt;
    logic        busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model: plain arrays, a pending-clear countdown and a popcount.
  logic [15:0] m_mem [2][8];
  logic        m_vld [2][8];
  int          m_left[2];
  logic        m_stq [2];
  logic        m_clq [2];

  int checks   = 0;
  int failures = 0;

  task automatic model_step(input int k, input int depth, input logic r,
                            input logic [15:0] d, input int a,
                            input logic st, input logic cl, output exp_t e);
    logic se, ce;
    int   n;
    if (r) begin
      for (int i = 0; i < 8; i++) m_vld[k][i] = 1'b0;
      m_left[k] = 0;
      m_stq[k]  = 1'b1;
      m_clq[k]  = 1'b1;
    end else begin
      se = st && !m_stq[k];
      ce = cl && !m_clq[k];
      m_stq[k] = st;
      m_clq[k] = cl;
      if (m_left[k] > 0) begin
        m_mem[k][depth - m_left[k]] = '0;
        m_vld[k][depth - m_left[k]] = 1'b0;
        m_left[k]--;
      end else if (ce) begin
        m_left[k] = depth;
      end else if (se) begin
        m_mem[k][a] = d;
        m_vld[k][a] = 1'b1;
      end
    end
    n = 0;
    for (int i = 0; i < depth; i++) n += int'(m_vld[k][i]);
    e.mem  = m_vld[k][a] ? m_mem[k][a] : 16'h0;
    e.vld  = m_vld[k][a];
    e.cnt  = 4'(n);
    e.busy = (m_left[k] > 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    model_step(0, 4, rst_a, 16'(bus_a.data), int'(bus_a.addr), bus_a.store, bus_a.clear, e);
    q_a.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    model_step(1, 8, rst_b, 16'(bus_b.data), int'(bus_b.addr), bus_b.store, bus_b.clear, e);
    q_b.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input exp_t act);
    chk({tag, ".memory"}, 32'(act.mem),  32'(e.mem));
    chk({tag, ".valid"},  32'(act.vld),  32'(e.vld));
    chk({tag, ".count"},  32'(act.cnt),  32'(e.cnt));
    chk({tag, ".busy"},   32'(act.busy), 32'(e.busy));
  endtask

  // Monitors: compare every presented output against the queued expectation.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      exp_t e, act;
      e = q_a.pop_front();
      act.mem  = 16'(bus_a.memory);
      act.vld  = bus_a.valid;
      act.cnt  = 4'(bus_a.count);
      act.busy = bus_a.busy;
      compare("A", e, act);
    end
  end

  always @(negedge clk) begin
    if (q_b.size() > 0) begin
      exp_t e, act;
      e = q_b.pop_front();
      act.mem  = bus_b.memory;
      act.vld  = bus_b.valid;
      act.cnt  = bus_b.count;
      act.busy = bus_b.busy;
      compare("B", e, act);
    end
  end

  task automatic rand_phase(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (k == 0) begin
        rst_a      = ($urandom_range(0, 63) == 0);
        bus_a.data = DWA'($urandom);
        bus_a.addr = AWA'($urandom);
        if ($urandom_range(0, 2) == 0)  bus_a.store = ~bus_a.store;
        if ($urandom_range(0, 15) == 0) bus_a.clear = ~bus_a.clear;
      end else begin
        rst_b      = ($urandom_range(0, 63) == 0);
        bus_b.data = DWB'($urandom);
        bus_b.addr = AWB'($urandom);
        if ($urandom_range(0, 2) == 0)  bus_b.store = ~bus_b.store;
        if ($urandom_range(0, 15) == 0) bus_b.clear = ~bus_b.clear;
      end
    end
    @(negedge clk);
    if (k == 0) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.data = '0; bus_a.addr = '0; bus_a.store = 1'b1; bus_a.clear = 1'b1;
    bus_b.data = '0; bus_b.addr = '0; bus_b.store = 1'b0; bus_b.clear = 1'b0;

    // ---------------- instance A: 8-bit words, DEPTH 4 ----------------
    repeat (3) @(negedge clk);
    rst_a = 1'b0;                       // store/clear still held high
    repeat (3) @(negedge clk);
    chk("A.rst_count",  32'(bus_a.count),  0);
    chk("A.rst_valid",  32'(bus_a.valid),  0);
    chk("A.rst_busy",   32'(bus_a.busy),   0);
    chk("A.rst_memory", 32'(bus_a.memory), 0);
    bus_a.store = 1'b0; bus_a.clear = 1'b0;
    @(negedge clk);

    bus_a.addr = 2'd2; bus_a.data = 8'hA5; bus_a.store = 1'b1;
    @(negedge clk);
    chk("A.wr_memory", 32'(bus_a.memory), 32'hA5);
    chk("A.wr_valid",  32'(bus_a.valid),  1);
    chk("A.wr_count",  32'(bus_a.count),  1);
    repeat (10) @(negedge clk);
    chk("A.hold_count", 32'(bus_a.count), 1);
    bus_a.store = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      bus_a.addr = AWA'(i); bus_a.data = DWA'((i + 1) * 8'h11); bus_a.store = 1'b1;
      @(negedge clk);
      bus_a.store = 1'b0;
      @(negedge clk);
    end
    for (int i = 3; i >= 0; i--) begin
      bus_a.addr = AWA'(i);
      @(negedge clk);
      chk("A.sweep_memory", 32'(bus_a.memory), 32'((i + 1) * 8'h11));
    end
    chk("A.full_count", 32'(bus_a.count), 4);
    bus_a.addr = 2'd1; bus_a.data = 8'h55; bus_a.store = 1'b1;
    @(negedge clk);
    chk("A.rewrite_count",  32'(bus_a.count),  4);
    chk("A.rewrite_memory", 32'(bus_a.memory), 32'h55);
    bus_a.store = 1'b0;
    @(negedge clk);

    // Clear-all with a store edge injected while busy.
    bus_a.clear = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_a.busy) begin
        n++;
        if (n == 2) bus_a.store = 1'b1;
      end else if (n > 0) break;
    end
    chk("A.clear_busy_cycles", 32'(n), 4);
    chk("A.clear_count", 32'(bus_a.count), 0);
    bus_a.clear = 1'b0; bus_a.store = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.addr = AWA'(i);
      @(negedge clk);
      chk("A.cleared_valid",  32'(bus_a.valid),  0);
      chk("A.cleared_memory", 32'(bus_a.memory), 0);
    end

    // Simultaneous store and clear edges: clear wins.
    bus_a.addr = 2'd3; bus_a.data = 8'h77;
    bus_a.store = 1'b1; bus_a.clear = 1'b1;
    @(negedge clk);
    chk("A.both_busy", 32'(bus_a.busy), 1);
    repeat (6) @(negedge clk);
    chk("A.both_count", 32'(bus_a.count), 0);
    chk("A.both_valid", 32'(bus_a.valid), 0);
    bus_a.store = 1'b0; bus_a.clear = 1'b0;

    rand_phase(0, 400);

    // ---------------- instance B: 16-bit words, DEPTH 8 ----------------
    rst_b = 1'b0;
    @(negedge clk);
    bus_b.addr = 3'd7; bus_b.data = 16'hBEEF; bus_b.store = 1'b1;
    @(negedge clk);
    bus_b.store = 1'b0;
    @(negedge clk);
    bus_b.addr = 3'd0; bus_b.data = 16'h1234; bus_b.store = 1'b1;
    @(negedge clk);
    chk("B.wr0_memory", 32'(bus_b.memory), 32'h1234);
    bus_b.store = 1'b0;
    bus_b.addr  = 3'd7;
    @(negedge clk);
    chk("B.wr7_memory", 32'(bus_b.memory), 32'hBEEF);
    chk("B.count2",     32'(bus_b.count),  2);

    bus_b.clear = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus_b.busy) n++;
      else if (n > 0) break;
    end
    chk("B.clear_busy_cycles", 32'(n), 8);
    chk("B.clear_count", 32'(bus_b.count), 0);
    bus_b.clear = 1'b0;
    @(negedge clk);

    // Reset in the middle of a clear sweep.
    bus_b.addr = 3'd4; bus_b.data = 16'hCAFE; bus_b.store = 1'b1;
    @(negedge clk);
    bus_b.store = 1'b0; bus_b.clear = 1'b1;
    repeat (3) @(negedge clk);
    chk("B.midclear_busy", 32'(bus_b.busy), 1);
    rst_b = 1'b1;
    @(negedge clk);
    chk("B.rst_busy",  32'(bus_b.busy),  0);
    chk("B.rst_count", 32'(bus_b.count), 0);
    rst_b = 1'b0; bus_b.clear = 1'b0;
    @(negedge clk);

    rand_phase(1, 400);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_bank.md
Name: memory_bank

Overview:
- Parametrised, clocked successor to the four-byte switch/LED memory system: DEPTH words of DATA_WIDTH bits behind one shared address.
- Adds edge-detected store, per-word valid tracking, a registered read port, an occupancy count and a multi-cycle clear-all sequencer.
- Sits between the board switches/buttons (data, addr, store, clear) and the LED display (memory, valid, count).

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 2, address width. DEPTH = 2**ADDR_WIDTH words (derived, not overridable).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  DATA_WIDTH  word to store.
- addr  input  ADDR_WIDTH  selects the word to write and to display.
- store  input  1  level input; a rising edge requests a write.
- clear  input  1  level input; a rising edge requests clear-all.
- memory  output  DATA_WIDTH  registered read data of word[addr]; 0 if that word is not valid.
- valid  output  1  registered valid bit of word[addr].
- count  output  ADDR_WIDTH+1  number of valid words, 0..DEPTH.
- busy  output  1  high while the clear sequencer runs.

Behaviour:
- Reset (rst high at a clock edge):
  - memory=0, valid=0, count=0, busy=0.
  - All valid bits = 0. State = IDLE. Clear pointer = 0.
  - store_q and clear_q load 1, so an input held high through reset does not fire after reset.
  - The array contents are not reset; the valid bits mask them.
- Edge detect:
  - store_q <= store and clear_q <= clear every cycle.
  - st_edge = store & ~store_q; cl_edge = clear & ~clear_q.
  - One request per edge; a held level never repeats.
- FSM states: IDLE and CLEAR.
  - IDLE, cl_edge: go to CLEAR, pointer = 0, busy = 1 from the next cycle. Clear wins over a simultaneous st_edge, which is dropped.
  - IDLE, st_edge only: word[addr] <= data, valid[addr] <= 1. count increments only if the word was previously invalid; overwriting a valid word leaves count unchanged.
  - CLEAR: each cycle, word[ptr] <= 0 and valid[ptr] <= 0, then ptr++.
  - CLEAR exit: the cycle that clears ptr = DEPTH-1 returns to IDLE. busy is high for exactly DEPTH cycles. count = 0 on exit.
  - CLEAR, st_edge or cl_edge: ignored and dropped, not queued.
- Read port: one-cycle latency.
  - memory_r <= valid_next[addr] ? word_next[addr] : 0.
  - valid_r <= valid_next[addr].
  - Write-first: a write to the currently addressed word is visible on memory/valid the cycle after the edge is sampled. No extra bubble.
- addr change: memory/valid reflect the new address one cycle later.
- count: registered. It is updated in the same cycle as the valid bits and never exceeds DEPTH.
- Reset mid-CLEAR: returns to IDLE immediately and all valid bits are cleared.

Test Plan:
- Reset, then store/clear held high across release -> no write; count=0, memory=0, valid=0, busy=0.
- addr=2, data=0xA5, store 0->1 -> one cycle later memory=0xA5, valid=1, count=1. Holding store high for 10 cycles -> count stays 1.
- Write 0x11,0x22,0x33,0x44 to addr 0..3, sweep addr 3..0 -> memory shows 0x44,0x33,0x22,0x11, each one cycle after the addr change. count=4. Rewrite addr 1 with 0x55 -> count stays 4.
- Full memory, clear edge -> busy high exactly 4 cycles (DEPTH=4). Afterwards count=0, and every addr reads memory=0, valid=0. A store edge during busy leaves count=0.
- Same-cycle store and clear edges in IDLE -> clear sequence runs, no write, final count=0.
- DATA_WIDTH=16, ADDR_WIDTH=3: write 0xBEEF to addr 7 and 0x1234 to addr 0 -> readback correct, count=2. Clear takes 8 busy cycles. rst asserted mid-clear -> busy=0 next cycle, count=0.
